riscv_ahb_sram_slave: RTL and testbench
=======================================

# riscv_ahb_sram_slave

AHB-Lite responder with SRAM-style storage that sits on one slave port of the bus interconnect, at the far end of the `slv_*` signal bundle. It accepts address phases from whichever master the interconnect has granted, and returns OKAY or two-cycle ERROR responses with a configurable number of wait states. Writes are byte-lane merged into a word-organised register array. It serves as the on-chip scratchpad/boot RAM and as the reference responder for interconnect verification.

## Interface
- PLEN, 64, address width
- XLEN, 64, data width (32 or 64)
- DEPTH, 1024, number of XLEN-bit words
- WAIT_STATES, 0, HREADYOUT-low cycles inserted in every OKAY data phase (0..15)

Ports:
- HCLK  in  1  clock; all state changes on rising edge
- HRESET  in  1  asynchronous, active-high reset
- HSEL  in  1  slave select from the interconnect
- HADDR  in  PLEN  byte address
- HWDATA  in  XLEN  write data, valid during the write data phase
- HRDATA  out  XLEN  read data
- HWRITE  in  1  1 = write
- HSIZE  in  3  transfer size, log2 of bytes
- HBURST  in  3  ignored
- HPROT  in  4  ignored
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
- HMASTLOCK  in  1  ignored
- HREADY  in  1  combined bus HREADY
- HREADYOUT  out  1  this slave's ready
- HRESP  out  1  0 = OKAY, 1 = ERROR

## Operation
- Address phase is accepted when HSEL & HREADY & HTRANS[1]. The block latches HADDR, HWRITE and HSIZE.
- IDLE or BUSY with HSEL & HREADY, or an unselected cycle: no transfer. The next cycle is a zero-wait OKAY, and no memory access occurs.
- An accepted transfer is an error when any of the following holds:
  - HSIZE > log2(XLEN/8)
  - the address is misaligned to HSIZE
  - the word index HADDR[PLEN-1:log2(XLEN/8)] ≥ DEPTH
- State machine:
  - IDLE: HREADYOUT=1, HRESP=0.
    - Valid accept, WAIT_STATES>0: go to WAIT with cnt = WAIT_STATES.
    - Valid accept, WAIT_STATES=0: go to DATA.
    - Error accept: go to ERR1.
  - WAIT: HREADYOUT=0, HRESP=0. cnt decrements each cycle. At cnt=1, go to DATA.
  - DATA: HREADYOUT=1, HRESP=0. The transfer completes this cycle.
    - A new accept in the same cycle follows the same rules as in IDLE.
    - Otherwise go to IDLE.
  - ERR1: HREADYOUT=0, HRESP=1. Always go to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. A new accept here is handled as in IDLE; otherwise go to IDLE.
- Writes: at the rising edge ending DATA, the bytes of HWDATA for lanes [off, off+2^HSIZE-1] are written into mem[word].
  - off is the latched HADDR[log2(XLEN/8)-1:0].
  - Other lanes are unchanged.
  - Errored writes never modify memory.
- Reads: in DATA, HRDATA = mem[word], the full word with all lanes driven. HRDATA = 0 in every other cycle.
- A read immediately following a write to the same word returns the new data, because the write commits at the edge that starts the read data phase.
- Memory is not reset. All control state is reset.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0. State = IDLE, cnt = 0, latched address phase cleared.
- Reset asserted mid-transfer (WAIT, DATA, ERR1): the transfer is aborted and an uncommitted write is dropped. The block is back in IDLE on the first edge after HRESET falls.
- OKAY latency: the address phase at edge N is followed by a data phase of WAIT_STATES+1 cycles. HREADYOUT rises in cycle N+1+WAIT_STATES.
- Error: the response is always exactly 2 cycles (ERR1, ERR2), independent of WAIT_STATES.
- Back-to-back NONSEQ/SEQ transfers with WAIT_STATES=0 give one transfer per cycle.
- Address phases are ignored while HREADY=0. This includes the case where another slave is stalling the bus.

## Test plan
- XLEN=64, WAIT_STATES=0: write 0x1122334455667788 to 0x10 (HSIZE=3), then read 0x10 → OKAY and HRDATA=0x1122334455667788, with HREADYOUT never low.
- Byte write 0xAB to 0x13 (HSIZE=0) after the full write above, then read 0x10 → 0x11223344AB667788 on little-endian lane 3.
- WAIT_STATES=3, single read → HREADYOUT low for exactly 3 cycles, then high with data. A second NONSEQ issued in the final data cycle is accepted.
- Read of word index 1024 (HADDR=0x2000), and separately HSIZE=2 at HADDR=0x2 → ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (1,1). Memory is unchanged, verified by readback.
- HTRANS=BUSY with HSEL=1 between two SEQ writes → zero-wait OKAY and no memory write. Both SEQ writes land correctly.
- Assert HRESET during the second WAIT cycle of a write (WAIT_STATES=3) → outputs return to 1/0/0 asynchronously, and a later read of that address returns the old contents.

Source files
------------

// File: rtl/riscv_ahb_sram_slave_if.sv
// AHB-Lite slave-port bundle between the interconnect and an SRAM responder.
// Latency: none, this is wiring only.
// Backpressure: HREADY is the combined bus ready and HREADYOUT is the slave's own ready.
// Ports: HSEL/HADDR/HWDATA/HWRITE/HSIZE/HBURST/HPROT/HTRANS/HMASTLOCK/HREADY go toward the slave.
//        HRDATA/HREADYOUT/HRESP come back from the slave.
interface riscv_ahb_sram_slave_if #(
   parameter int PLEN = 64,
   parameter int XLEN = 64
);
   logic            HSEL;
   logic [PLEN-1:0] HADDR;
   logic [XLEN-1:0] HWDATA;
   logic [XLEN-1:0] HRDATA;
   logic            HWRITE;
   logic [2:0]      HSIZE;
   logic [2:0]      HBURST;
   logic [3:0]      HPROT;
   logic [1:0]      HTRANS;
   logic            HMASTLOCK;
   logic            HREADY;
   logic            HREADYOUT;
   logic            HRESP;

   modport master (
      output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY,
      input  HRDATA, HREADYOUT, HRESP
   );

   modport slave (
      input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY,
      output HRDATA, HREADYOUT, HRESP
   );
endinterface

// File: rtl/riscv_ahb_sram_slave.sv
// AHB-Lite SRAM responder with byte-lane merged writes into a word-organised array.
// Latency: OKAY data phase is WAIT_STATES+1 cycles; ERROR is always two cycles (ERR1, ERR2).
// Backpressure: HREADYOUT drops during wait states and ERR1; address phases are ignored while HREADY=0.
// Ports: HCLK, HRESET (async, active high), ahb (slave modport of riscv_ahb_sram_slave_if).
module riscv_ahb_sram_slave #(
   parameter int PLEN        = 64,
   parameter int XLEN        = 64,
   parameter int DEPTH       = 1024,
   parameter int WAIT_STATES = 0
) (
   input  logic                   HCLK,
   input  logic                   HRESET,
   riscv_ahb_sram_slave_if.slave  ahb
);
   localparam int BW   = XLEN / 8;
   localparam int OFFW = $clog2(BW);
   localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int IW   = PLEN - OFFW;
   localparam logic [3:0]    WS        = 4'(WAIT_STATES);
   localparam logic [IW-1:0] DEPTH_IDX = IW'(DEPTH);

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

   state_t          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [AW-1:0]   word_q, word_d;
   logic [OFFW-1:0] off_q, off_d;
   logic [2:0]      size_q, size_d;
   logic            write_q, write_d;
   logic            hreadyout_q, hreadyout_d;
   logic            hresp_q, hresp_d;

   logic [XLEN-1:0] mem [DEPTH];

   logic            accept;
   logic            addr_err;
   logic [OFFW-1:0] size_mask;
   logic [BW-1:0]   lane_en;
   logic            unused_ok;

   assign accept    = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];
   assign unused_ok = ^{ahb.HBURST, ahb.HPROT, ahb.HMASTLOCK, ahb.HTRANS[0]};

   // Oversize, misaligned or out-of-range transfers get the two-cycle ERROR response.
   always_comb begin
      size_mask = '0;
      for (int i = 0; i < OFFW; i++) begin
         size_mask[i] = (i < int'(ahb.HSIZE));
      end
      addr_err = (int'(ahb.HSIZE) > OFFW)
              || ((ahb.HADDR[OFFW-1:0] & size_mask) != '0)
              || (ahb.HADDR[PLEN-1:OFFW] >= DEPTH_IDX);
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      word_d  = word_q;
      off_d   = off_q;
      size_d  = size_q;
      write_d = write_q;
      case (state_q)
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = S_DATA;
         end
         S_ERR1: state_d = S_ERR2;
         default: begin
            // IDLE, DATA and ERR2 all drive HREADYOUT high, so a new address phase can land here.
            state_d = S_IDLE;
            if (accept) begin
               word_d  = ahb.HADDR[OFFW +: AW];
               off_d   = ahb.HADDR[OFFW-1:0];
               size_d  = ahb.HSIZE;
               write_d = ahb.HWRITE;
               if (addr_err) begin
                  state_d = S_ERR1;
               end else if (WS != 4'd0) begin
                  state_d = S_WAIT;
                  cnt_d   = WS;
               end else begin
                  state_d = S_DATA;
               end
            end
         end
      endcase
      // Response outputs are decoded from the next state so they come straight off flops.
      hreadyout_d = !((state_d == S_WAIT) || (state_d == S_ERR1));
      hresp_d     = (state_d == S_ERR1) || (state_d == S_ERR2);
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         word_q      <= '0;
         off_q       <= '0;
         size_q      <= '0;
         write_q     <= 1'b0;
         hreadyout_q <= 1'b1;
         hresp_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         word_q      <= word_d;
         off_q       <= off_d;
         size_q      <= size_d;
         write_q     <= write_d;
         hreadyout_q <= hreadyout_d;
         hresp_q     <= hresp_d;
      end
   end

   // Byte lanes covered by the latched transfer: [off, off + 2^size - 1].
   always_comb begin
      lane_en = '0;
      for (int i = 0; i < BW; i++) begin
         lane_en[i] = (i >= int'(off_q)) && (i < int'(off_q) + (1 << size_q));
      end
   end

   // Storage is not reset; an async reset forces state_q out of DATA so a pending write is dropped.
   always_ff @(posedge HCLK) begin
      if ((state_q == S_DATA) && write_q) begin
         for (int i = 0; i < BW; i++) begin
            if (lane_en[i]) mem[word_q][8*i +: 8] <= ahb.HWDATA[8*i +: 8];
         end
      end
   end

   assign ahb.HRDATA    = ((state_q == S_DATA) && !write_q) ? mem[word_q] : '0;
   assign ahb.HREADYOUT = hreadyout_q;
   assign ahb.HRESP     = hresp_q;
endmodule

// File: tb/tb_riscv_ahb_sram_slave.sv
module tb_riscv_ahb_sram_slave;
   localparam logic [1:0] T_IDLE = 2'd0, T_BUSY = 2'd1, T_NSEQ = 2'd2, T_SEQ = 2'd3;
   localparam logic [63:0] V_FULL = 64'h1122334455667788;
   localparam logic [63:0] V_SEED = 64'hCAFEF00D12345678;
   localparam logic [63:0] V_A    = 64'hA5A5000011112222;
   localparam logic [63:0] V_B    = 64'h3333444455556666;
   localparam logic [63:0] V_OLD  = 64'h0102030405060708;
   localparam logic [63:0] V_NEW  = 64'hF0E0D0C0B0A09080;

   logic clk = 1'b0;
   logic rst0, rst3;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   riscv_ahb_sram_slave_if #(.PLEN(64), .XLEN(64)) bus0 ();
   riscv_ahb_sram_slave_if #(.PLEN(64), .XLEN(64)) bus3 ();

   // Each responder is the only slave on its bus, so the combined HREADY is its own HREADYOUT.
   assign bus0.HREADY = bus0.HREADYOUT;
   assign bus3.HREADY = bus3.HREADYOUT;

   riscv_ahb_sram_slave #(.PLEN(64), .XLEN(64), .DEPTH(1024), .WAIT_STATES(0)) u_dut0 (
      .HCLK(clk), .HRESET(rst0), .ahb(bus0));
   riscv_ahb_sram_slave #(.PLEN(64), .XLEN(64), .DEPTH(1024), .WAIT_STATES(3)) u_dut3 (
      .HCLK(clk), .HRESET(rst3), .ahb(bus3));

   // Drive one bus cycle just after the rising edge, then stop at the falling edge for sampling.
   task automatic drv(input bit d, input logic [1:0] trans, input logic wr,
                      input logic [63:0] addr, input logic [2:0] size, input logic [63:0] wdata);
      @(posedge clk); #1;
      if (!d) begin
         bus0.HSEL = 1'b1; bus0.HTRANS = trans; bus0.HWRITE = wr;
         bus0.HADDR = addr; bus0.HSIZE = size; bus0.HWDATA = wdata;
      end else begin
         bus3.HSEL = 1'b1; bus3.HTRANS = trans; bus3.HWRITE = wr;
         bus3.HADDR = addr; bus3.HSIZE = size; bus3.HWDATA = wdata;
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst0 = 1'b1; rst3 = 1'b1;
      bus0.HSEL = 0; bus0.HTRANS = T_IDLE; bus0.HWRITE = 0; bus0.HADDR = '0; bus0.HSIZE = '0;
      bus0.HWDATA = '0; bus0.HBURST = '0; bus0.HPROT = '0; bus0.HMASTLOCK = 0;
      bus3.HSEL = 0; bus3.HTRANS = T_IDLE; bus3.HWRITE = 0; bus3.HADDR = '0; bus3.HSIZE = '0;
      bus3.HWDATA = '0; bus3.HBURST = '0; bus3.HPROT = '0; bus3.HMASTLOCK = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (bus0.HREADYOUT !== 1'b1) begin failures++; $display("FAIL rst0_hreadyout act=%b exp=1", bus0.HREADYOUT); end
      checks++; if (bus0.HRESP !== 1'b0) begin failures++; $display("FAIL rst0_hresp act=%b exp=0", bus0.HRESP); end
      checks++; if (bus0.HRDATA !== 64'h0) begin failures++; $display("FAIL rst0_hrdata act=%h exp=0", bus0.HRDATA); end
      checks++; if (bus3.HREADYOUT !== 1'b1) begin failures++; $display("FAIL rst3_hreadyout act=%b exp=1", bus3.HREADYOUT); end
      checks++; if (bus3.HRESP !== 1'b0) begin failures++; $display("FAIL rst3_hresp act=%b exp=0", bus3.HRESP); end
      checks++; if (bus3.HRDATA !== 64'h0) begin failures++; $display("FAIL rst3_hrdata act=%h exp=0", bus3.HRDATA); end
      @(posedge clk); #1;
      rst0 = 1'b0; rst3 = 1'b0;
   endtask

   task automatic test_full_write_read();
      drv(0, T_NSEQ, 1, 64'h10, 3'd3, 64'h0);
      checks++; if (bus0.HREADYOUT !== 1'b1) begin failures++; $display("FAIL full_addr_rdy act=%b exp=1", bus0.HREADYOUT); end
      drv(0, T_NSEQ, 0, 64'h10, 3'd3, V_FULL);
      checks++; if (bus0.HREADYOUT !== 1'b1 || bus0.HRESP !== 1'b0) begin failures++; $display("FAIL full_wdata_resp act=%b/%b exp=1/0", bus0.HREADYOUT, bus0.HRESP); end
      drv(0, T_IDLE, 0, 64'h0, 3'd0, 64'h0);
      checks++; if (bus0.HREADYOUT !== 1'b1 || bus0.HRESP !== 1'b0) begin failures++; $display("FAIL full_rdata_resp act=%b/%b exp=1/0", bus0.HREADYOUT, bus0.HRESP); end
      checks++; if (bus0.HRDATA !== V_FULL) begin failures++; $display("FAIL full_rdata act=%h exp=%h", bus0.HRDATA, V_FULL); end
      drv(0, T_IDLE, 0, 64'h0, 3'd0, 64'h0);
      checks++; if (bus0.HRDATA !== 64'h0) begin failures++; $display("FAIL full_rdata_idle act=%h exp=0", bus0.HRDATA); end
   endtask

   task automatic test_byte_write();
      drv(0, T_NSEQ, 1, 64'h13, 3'd0, 64'h0);
      drv(0, T_NSEQ, 0, 64'h10, 3'd3, 64'h00000000AB000000);
      checks++; if (bus0.HREADYOUT !== 1'b1) begin failures++; $display("FAIL byte_wdata_rdy act=%b exp=1", bus0.HREADYOUT); end
      drv(0, T_IDLE, 0, 64'h0, 3'd0, 64'h0);
      checks++; if (bus0.HRDATA !== 64'h11223344AB667788) begin failures++; $display("FAIL byte_merge act=%h exp=11223344ab667788", bus0.HRDATA); end
   endtask

   task automatic test_errors();
      drv(0, T_NSEQ, 1, 64'h0, 3'd3, 64'h0);
      drv(0, T_IDLE, 0, 64'h0, 3'd0, V_SEED);
      // Word index 1024 is just past the end.
      drv(0, T_NSEQ, 0, 64'h2000, 3'd3, 64'h0);
      checks++; if (bus0.HRESP !== 1'b0) begin failures++; $display("FAIL err_range_pre act=%b exp=0", bus0.HRESP); end
      drv(0, T_IDLE, 0, 64'h0, 3'd0, 64'h0);
      checks++; if (bus0.HREADYOUT !== 1'b0 || bus0.HRESP !== 1'b1) begin failures++; $display("FAIL err_range_err1 act=%b/%b exp=0/1", bus0.HREADYOUT, bus0.HRESP); end
      checks++; if (bus0.HRDATA !== 64'h0) begin failures++; $display("FAIL err_range_rdata act=%h exp=0", bus0.HRDATA); end
      drv(0, T_IDLE, 0, 64'h0, 3'd0, 64'h0);
      checks++; if (bus0.HREADYOUT !== 1'b1 || bus0.HRESP !== 1'b1) begin failures++; $display("FAIL err_range_err2 act=%b/%b exp=1/1", bus0.HREADYOUT, bus0.HRESP); end
      // Misaligned word write inside word 0 must not touch it.
      drv(0, T_NSEQ, 1, 64'h2, 3'd2, 64'h0);
      checks++; if (bus0.HREADYOUT !== 1'b1 || bus0.HRESP !== 1'b0) begin failures++; $display("FAIL err_mis_pre act=%b/%b exp=1/0", bus0.HREADYOUT, bus0.HRESP); end
      drv(0, T_IDLE, 0, 64'h0, 3'd0, 64'hFFFFFFFFFFFFFFFF);
      checks++; if (bus0.HREADYOUT !== 1'b0 || bus0.HRESP !== 1'b1) begin failures++; $display("FAIL err_mis_err1 act=%b/%b exp=0/1", bus0.HREADYOUT, bus0.HRESP); end
      drv(0, T_IDLE, 0, 64'h0, 3'd0, 64'hFFFFFFFFFFFFFFFF);
      checks++; if (bus0.HREADYOUT !== 1'b1 || bus0.HRESP !== 1'b1) begin failures++; $display("FAIL err_mis_err2 act=%b/%b exp=1/1", bus0.HREADYOUT, bus0.HRESP); end
      // Oversize (16-byte) transfer on a 64-bit slave.
      drv(0, T_NSEQ, 0, 64'h0, 3'd4, 64'h0);
      drv(0, T_IDLE, 0, 64'h0, 3'd0, 64'h0);
      checks++; if (bus0.HREADYOUT !== 1'b0 || bus0.HRESP !== 1'b1) begin failures++; $display("FAIL err_size_err1 act=%b/%b exp=0/1", bus0.HREADYOUT, bus0.HRESP); end
      drv(0, T_IDLE, 0, 64'h0, 3'd0, 64'h0);
      drv(0, T_NSEQ, 0, 64'h0, 3'd3, 64'h0);
      checks++; if (bus0.HREADYOUT !== 1'b1 || bus0.HRESP !== 1'b0) begin failures++; $display("FAIL err_after_idle act=%b/%b exp=1/0", bus0.HREADYOUT, bus0.HRESP); end
      drv(0, T_IDLE, 0, 64'h0, 3'd0, 64'h0);
      checks++; if (bus0.HRDATA !== V_SEED) begin failures++; $display("FAIL err_mem_intact act=%h exp=%h", bus0.HRDATA, V_SEED); end
   endtask

   task automatic test_back_to_back();
      drv(0, T_NSEQ, 1, 64'h20, 3'd3, 64'h0);
      drv(0, T_BUSY, 1, 64'h28, 3'd3, V_A);
      checks++; if (bus0.HREADYOUT !== 1'b1 || bus0.HRESP !== 1'b0) begin failures++; $display("FAIL b2b_busy_cycle act=%b/%b exp=1/0", bus0.HREADYOUT, bus0.HRESP); end
      // Data bus carries junk after BUSY; nothing may be written from it.
      drv(0, T_SEQ, 1, 64'h28, 3'd3, 64'hDEADDEADDEADDEAD);
      checks++; if (bus0.HREADYOUT !== 1'b1 || bus0.HRESP !== 1'b0) begin failures++; $display("FAIL b2b_after_busy act=%b/%b exp=1/0", bus0.HREADYOUT, bus0.HRESP); end
      drv(0, T_NSEQ, 0, 64'h20, 3'd3, V_B);
      checks++; if (bus0.HREADYOUT !== 1'b1) begin failures++; $display("FAIL b2b_seq_wdata act=%b exp=1", bus0.HREADYOUT); end
      drv(0, T_SEQ, 0, 64'h28, 3'd3, 64'h0);
      checks++; if (bus0.HREADYOUT !== 1'b1 || bus0.HRDATA !== V_A) begin failures++; $display("FAIL b2b_rd20 act=%b/%h exp=1/%h", bus0.HREADYOUT, bus0.HRDATA, V_A); end
      drv(0, T_IDLE, 0, 64'h0, 3'd0, 64'h0);
      checks++; if (bus0.HREADYOUT !== 1'b1 || bus0.HRDATA !== V_B) begin failures++; $display("FAIL b2b_rd28 act=%b/%h exp=1/%h", bus0.HREADYOUT, bus0.HRDATA, V_B); end
   endtask

   task automatic test_wait_states();
      drv(1, T_NSEQ, 1, 64'h40, 3'd3, 64'h0);
      for (int i = 0; i < 3; i++) begin
         drv(1, T_IDLE, 0, 64'h0, 3'd0, V_OLD);
         checks++; if (bus3.HREADYOUT !== 1'b0 || bus3.HRESP !== 1'b0) begin failures++; $display("FAIL ws_wr_wait%0d act=%b/%b exp=0/0", i, bus3.HREADYOUT, bus3.HRESP); end
      end
      drv(1, T_IDLE, 0, 64'h0, 3'd0, V_OLD);
      checks++; if (bus3.HREADYOUT !== 1'b1) begin failures++; $display("FAIL ws_wr_data act=%b exp=1", bus3.HREADYOUT); end
      drv(1, T_NSEQ, 0, 64'h40, 3'd3, 64'h0);
      for (int i = 0; i < 3; i++) begin
         drv(1, T_IDLE, 0, 64'h0, 3'd0, 64'h0);
         checks++; if (bus3.HREADYOUT !== 1'b0 || bus3.HRDATA !== 64'h0) begin failures++; $display("FAIL ws_rd_wait%0d act=%b/%h exp=0/0", i, bus3.HREADYOUT, bus3.HRDATA); end
      end
      // New NONSEQ presented in the final data cycle.
      drv(1, T_NSEQ, 0, 64'h40, 3'd3, 64'h0);
      checks++; if (bus3.HREADYOUT !== 1'b1 || bus3.HRDATA !== V_OLD) begin failures++; $display("FAIL ws_rd_data act=%b/%h exp=1/%h", bus3.HREADYOUT, bus3.HRDATA, V_OLD); end
      for (int i = 0; i < 3; i++) begin
         drv(1, T_IDLE, 0, 64'h0, 3'd0, 64'h0);
         checks++; if (bus3.HREADYOUT !== 1'b0) begin failures++; $display("FAIL ws_rd2_wait%0d act=%b exp=0", i, bus3.HREADYOUT); end
      end
      drv(1, T_IDLE, 0, 64'h0, 3'd0, 64'h0);
      checks++; if (bus3.HREADYOUT !== 1'b1 || bus3.HRDATA !== V_OLD) begin failures++; $display("FAIL ws_rd2_data act=%b/%h exp=1/%h", bus3.HREADYOUT, bus3.HRDATA, V_OLD); end
   endtask

   task automatic test_reset_mid_wait();
      drv(1, T_NSEQ, 1, 64'h40, 3'd3, 64'h0);
      drv(1, T_IDLE, 0, 64'h0, 3'd0, V_NEW);
      drv(1, T_IDLE, 0, 64'h0, 3'd0, V_NEW);
      checks++; if (bus3.HREADYOUT !== 1'b0) begin failures++; $display("FAIL rmw_wait2 act=%b exp=0", bus3.HREADYOUT); end
      #1 rst3 = 1'b1;
      #1;
      checks++; if (bus3.HREADYOUT !== 1'b1 || bus3.HRESP !== 1'b0 || bus3.HRDATA !== 64'h0) begin
         failures++; $display("FAIL rmw_async act=%b/%b/%h exp=1/0/0", bus3.HREADYOUT, bus3.HRESP, bus3.HRDATA); end
      @(posedge clk); #1;
      rst3 = 1'b0;
      drv(1, T_IDLE, 0, 64'h0, 3'd0, V_NEW);
      checks++; if (bus3.HREADYOUT !== 1'b1) begin failures++; $display("FAIL rmw_idle act=%b exp=1", bus3.HREADYOUT); end
      drv(1, T_NSEQ, 0, 64'h40, 3'd3, 64'h0);
      repeat (3) drv(1, T_IDLE, 0, 64'h0, 3'd0, 64'h0);
      drv(1, T_IDLE, 0, 64'h0, 3'd0, 64'h0);
      checks++; if (bus3.HREADYOUT !== 1'b1 || bus3.HRDATA !== V_OLD) begin failures++; $display("FAIL rmw_old_data act=%b/%h exp=1/%h", bus3.HREADYOUT, bus3.HRDATA, V_OLD); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_full_write_read();
      test_byte_write();
      test_errors();
      test_back_to_back();
      test_wait_states();
      test_reset_mid_wait();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
